fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side consumer for the team's FIFO. It drains the FIFO's pop interface (read strobe, empty flag, rdata valid one cycle after the strobe) and presents the bytes as a valid/ready stream. The stream carries packet framing (m_last every PKT_LEN beats). It sits between the FIFO read port and downstream stream logic. It sustains one beat per clock and never over-reads an empty FIFO.

Parameters:
DW, 8, data width in bits; must equal the FIFO data width.
PKT_LEN, 16, beats per packet; m_last is asserted on beat PKT_LEN-1. Legal range 1..65535.
BUF_DEPTH, 2, output buffer entries; fixed at 2 and equal to the credit limit.

Ports:
clk  input  1  single clock, rising edge; the same clock as the FIFO read side.
rst  input  1  asynchronous reset, active-high.
enable  input  1  permits new FIFO reads; does not gate the delivery of data already fetched.
fifo_empty  input  1  FIFO empty flag, synchronous to clk.
fifo_rdata  input  DW  FIFO read data, valid in the cycle after fifo_read.
fifo_read  output  1  FIFO pop strobe, combinational.
m_valid  output  1  stream beat valid.
m_data  output  DW  stream data.
m_last  output  1  last beat of the current packet.
m_ready  input  1  downstream accept.
pkt_cnt  output  16  completed packets since reset; wraps at 65535 to 0.
busy  output  1  high while any read is in flight or any buffer entry is occupied.

Behaviour:
- Reset (async assert, sync release): fifo_read=0, m_valid=0, m_data=0, m_last=0, pkt_cnt=0, busy=0. The buffer is emptied, the in-flight flag is cleared and the beat counter is cleared.
- Beat acceptance: a beat is accepted when m_valid and m_ready are both high in a cycle.
- Read issue: fifo_read = enable & ~fifo_empty & (occ + inflight - accept < 2).
  - occ is the buffer occupancy (0..2).
  - inflight is 1 if fifo_read was high in the previous cycle.
  - accept is the acceptance of the current cycle.
- fifo_read is never high while fifo_empty is high.
- Latency: fifo_read high in cycle N, then fifo_rdata is captured at the end of N+1, then m_valid is high in N+2 (2-cycle first-beat latency).
- Throughput: with the FIFO non-empty and m_ready held high, fifo_read and accept are both high every cycle from steady state, i.e. one beat per clock.
- Ordering: strict FIFO order. m_data and m_last are held stable while m_valid=1 and m_ready=0.
- Buffer full: with occ=2 (or occ=1 plus one read in flight) and no accept, fifo_read is 0.
  - The captured in-flight beat always has a free slot; no overflow and no data loss is possible.
- Simultaneous capture and accept in the same cycle: occ is unchanged and the head advances.
- Framing:
  - A beat counter (0..PKT_LEN-1) is attached to the head beat. m_last = (beat_cnt == PKT_LEN-1) while m_valid.
  - On accept, beat_cnt increments, or wraps to 0 on the last beat; pkt_cnt increments on the accept of the last beat.
  - PKT_LEN=1 gives m_last on every beat.
- enable deasserted mid-stream: no new reads. The in-flight beat is still captured, and buffered beats drain normally. busy falls once occ=0 and inflight=0.
- fifo_empty asserting with a read in flight: the in-flight beat is still captured. No further reads are issued.
- Reset mid-operation: all state is cleared immediately. Buffered and in-flight data are discarded; the partial packet count restarts at 0.
  - An in-flight FIFO read at reset is lost. This is the accepted behaviour, because the FIFO shares the same reset.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DW = 8 default;
  - the stream beat typedef (data + last);
  - the credit constant RD_CREDITS = 2.
- One natural sub-module: stream_buf2, the 2-entry FIFO-ordered holding buffer.
  - Write port: capture strobe and data.
  - Read port: valid/ready.
  - Outputs: occupancy.
- The top level holds the credit logic, the in-flight flag, the beat counter and pkt_cnt.

Test Plan:
1. Reset values: assert rst mid-cycle with no clock edge. All outputs read 0 immediately; fifo_read stays 0 while rst is high even with fifo_empty=0.
2. Single byte: FIFO holds 0x01, m_ready=1, enable=1. fifo_read pulses one cycle in cycle N. m_valid=1 with m_data=0x01 in N+2. Then fifo_read=0 (fifo_empty=1), busy returns to 0 in N+3.
3. Streaming: FIFO pre-loaded with 0x01..0x20, PKT_LEN=16, m_ready=1.
   - 32 beats on consecutive cycles, in order.
   - m_last on 0x10 and 0x20.
   - pkt_cnt=2 at the end.
   - fifo_read is never high while fifo_empty=1.
4. Backpressure: same load, m_ready toggles every cycle (mirrors the FIFO bench read toggle).
   - No beat lost or duplicated; m_data is stable while stalled.
   - occ never exceeds 2; fifo_read=0 whenever the credit is exhausted.
5. Underrun: FIFO empties after 0x05 while m_ready=1. fifo_read drops the cycle fifo_empty asserts. 0x05 is delivered, then m_valid=0.
6. Refill, reset and enable:
   - Pushing 0x15.. later resumes delivery with beat_cnt continuing (m_last on the 16th beat overall).
   - Asserting rst with 2 beats buffered clears m_valid and pkt_cnt to 0.
   - Deasserting enable with 2 beats buffered still delivers both beats, then busy=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream consumer.
package fifo_pkg;

    // Default FIFO data width; the consumer's DW must match the FIFO it drains.
    localparam int FIFO_DW = 8;

    // Outstanding-beat limit: buffered beats plus the one read in flight.
    localparam int RD_CREDITS = 2;

    // One stream beat as seen downstream.
    typedef struct packed {
        logic [FIFO_DW-1:0] data;
        logic               last;
    } beat_t;

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// stream_buf2: two-entry, FIFO-ordered holding buffer between the FIFO read
// data and the valid/ready stream. The capture strobe is never asserted when
// the buffer is full (the parent's credit logic guarantees a free slot).
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem_reg [0:RD_CREDITS-1];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    occ_reg;
    logic          rd_fire;

    assign rd_valid = (occ_reg != 2'd0);
    assign rd_fire  = rd_valid & rd_ready;
    assign rd_data  = mem_reg[rd_ptr_reg];
    assign occ      = occ_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RD_CREDITS; gi++) begin : g_entry
            // Each slot loads only when the write pointer addresses it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    mem_reg[gi] <= '0;
                else if (wr_en && (wr_ptr_reg == 1'(gi)))
                    mem_reg[gi] <= wr_data;
            end
        end
    endgenerate

    // Pointers advance on capture/accept; occupancy tracks the difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (rd_fire)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({wr_en, rd_fire})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO pop interface into a valid/ready stream with
// packet framing. Reads are credit-limited so the captured beat always has a
// buffer slot, allowing one beat per clock without ever over-reading.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DW      = FIFO_DW,
    parameter int PKT_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_read,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic [15:0]   pkt_cnt,
    output logic          busy
);

    logic        inflight_reg;
    logic [15:0] beat_cnt_reg;
    logic [15:0] pkt_cnt_reg;
    logic [1:0]  occ;
    logic        accept;
    logic        is_last;
    logic [2:0]  used;

    stream_buf2 #(.DW(DW)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (inflight_reg),
        .wr_data  (fifo_rdata),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (m_data),
        .occ      (occ)
    );

    assign accept  = m_valid & m_ready;
    assign is_last = (beat_cnt_reg == 16'(PKT_LEN - 1));
    assign m_last  = m_valid & is_last;
    assign pkt_cnt = pkt_cnt_reg;
    assign busy    = (occ != 2'd0) | inflight_reg;

    // Beats committed (buffered + in flight); an accept this cycle frees one,
    // so comparing against credits + accept keeps the pipe full at one/clock.
    assign used      = {1'b0, occ} + {2'b00, inflight_reg};
    assign fifo_read = ~rst & enable & ~fifo_empty
                     & (used < (3'(RD_CREDITS) + {2'b00, accept}));

    // A read issued this cycle returns data next cycle; flag it for capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inflight_reg <= 1'b0;
        else
            inflight_reg <= fifo_read;
    end

    // Beat position of the head beat and completed-packet count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_reg <= 16'd0;
            pkt_cnt_reg  <= 16'd0;
        end else if (accept) begin
            if (is_last) begin
                beat_cnt_reg <= 16'd0;
                pkt_cnt_reg  <= pkt_cnt_reg + 16'd1;
            end else begin
                beat_cnt_reg <= beat_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO and a beat
// scoreboard that checks order, framing and stall stability.
module tb_fifo_rd_stream;

    localparam int DW      = 8;
    localparam int PKT_LEN = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_read;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic [15:0]   pkt_cnt;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural FIFO: pushed by the stimulus, popped by fifo_read.
    logic [DW-1:0] fmem [0:255];
    int wr_idx = 0;
    int rd_idx = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    // Scoreboard state (owned by the monitor, except pushes).
    logic [DW-1:0] exp_q [$];
    int            exp_beat = 0;
    int            rd_cnt = 0, acc_cnt = 0, max_out = 0, viol = 0;
    int            cyc = 0, first_acc = 0, last_acc = 0;
    logic          stall_pending = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          stall_last = 1'b0;
    logic [DW-1:0] last_tag_data = '0;
    logic [DW-1:0] exp_d;

    fifo_rd_stream #(.DW(DW), .PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_read  (fifo_read),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .pkt_cnt    (pkt_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx <= 0;
        end else if (fifo_read) begin
            fifo_rdata <= fmem[rd_idx[7:0]];
            rd_idx     <= rd_idx + 1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] b);
        fmem[wr_idx[7:0]] = b;
        wr_idx++;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        wr_idx = 0;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check_vec("idle_timeout", n < budget, 1);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            step();
            n++;
        end
        check_vec("acc_timeout", n < budget, 1);
    endtask

    // Monitor on the falling edge: inputs and outputs are settled for the
    // upcoming rising edge, so an accept seen here happens at that edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_beat = 0; rd_cnt = 0; acc_cnt = 0; max_out = 0; viol = 0;
            first_acc = 0; last_acc = 0; stall_pending = 1'b0;
        end else begin
            if (fifo_read && fifo_empty)
                viol++;
            if (stall_pending)
                check_vec("stall_hold", {m_valid, m_data, m_last}, {1'b1, stall_data, stall_last});
            if (fifo_read)
                rd_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_vec("extra_beat", 1, 0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check_vec("beat_data", m_data, exp_d);
                    check_vec("beat_last", m_last, (exp_beat == PKT_LEN - 1));
                end
                if (m_last)
                    last_tag_data = m_data;
                if (acc_cnt == 0)
                    first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
                exp_beat = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
            end
            if (rd_cnt - acc_cnt > max_out)
                max_out = rd_cnt - acc_cnt;
            stall_pending = m_valid && !m_ready;
            stall_data    = m_data;
            stall_last    = m_last;
        end
    end

    initial begin
        rst = 1'b0; enable = 1'b0; m_ready = 1'b0;

        // Reset values: asynchronous assert, no clock edge yet.
        #2 rst = 1'b1;
        push(8'hAA);
        enable = 1'b1;
        #1;
        check_vec("rst_fifo_read", fifo_read, 0);
        check_vec("rst_m_valid", m_valid, 0);
        check_vec("rst_m_data", m_data, 0);
        check_vec("rst_m_last", m_last, 0);
        check_vec("rst_pkt_cnt", pkt_cnt, 0);
        check_vec("rst_busy", busy, 0);
        step(); step();
        wr_idx = 0;
        rst = 1'b0;

        // Single byte: read in N, valid in N+2, idle in N+3.
        m_ready = 1'b1;
        push(8'h01);
        #1;
        check_vec("single_read_N", fifo_read, 1);
        step();
        check_vec("single_read_N1", fifo_read, 0);
        check_vec("single_busy_N1", busy, 1);
        check_vec("single_valid_N1", m_valid, 0);
        step();
        check_vec("single_valid_N2", m_valid, 1);
        check_vec("single_data_N2", m_data, 8'h01);
        check_vec("single_last_N2", m_last, 0);
        step();
        check_vec("single_busy_N3", busy, 0);
        check_vec("single_valid_N3", m_valid, 0);

        // Streaming 32 beats at full rate.
        do_reset();
        enable = 1'b0;
        for (int i = 1; i <= 32; i++) push(8'(i));
        #1;
        check_vec("enable_gate", fifo_read, 0);
        enable = 1'b1;
        wait_idle(100);
        check_vec("stream_count", acc_cnt, 32);
        check_vec("stream_gapless", last_acc - first_acc, 31);
        check_vec("stream_pkt_cnt", pkt_cnt, 2);
        check_vec("stream_last_tag", last_tag_data, 8'h20);
        check_vec("stream_no_empty_read", viol, 0);

        // Backpressure: m_ready toggles every cycle.
        do_reset();
        for (int i = 1; i <= 32; i++) push(8'(i));
        for (int n = 0; n < 200 && acc_cnt < 32; n++) begin
            m_ready = ~m_ready;
            step();
        end
        m_ready = 1'b1;
        wait_idle(20);
        check_vec("bp_count", acc_cnt, 32);
        check_vec("bp_pkt_cnt", pkt_cnt, 2);
        check_vec("bp_credit_max", max_out <= 2, 1);
        check_vec("bp_no_empty_read", viol, 0);

        // Underrun after 0x05.
        do_reset();
        enable = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        enable = 1'b1;
        begin
            int n = 0;
            while (!fifo_empty && n < 20) begin step(); n++; end
            check_vec("underrun_empty_seen", fifo_empty, 1);
        end
        check_vec("underrun_read_drop", fifo_read, 0);
        wait_idle(20);
        check_vec("underrun_count", acc_cnt, 5);
        check_vec("underrun_valid", m_valid, 0);
        check_vec("underrun_no_empty_read", viol, 0);

        // Refill continues the framing: 16th beat overall carries m_last.
        for (int i = 'h15; i <= 'h1F; i++) push(8'(i));
        wait_idle(50);
        check_vec("refill_count", acc_cnt, 16);
        check_vec("refill_pkt_cnt", pkt_cnt, 1);
        check_vec("refill_last_tag", last_tag_data, 8'h1F);

        // Reset with two beats buffered.
        m_ready = 1'b0;
        for (int i = 'h30; i < 'h34; i++) push(8'(i));
        repeat (5) step();
        check_vec("rstmid_valid_before", m_valid, 1);
        check_vec("rstmid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_vec("rstmid_valid", m_valid, 0);
        check_vec("rstmid_pkt_cnt", pkt_cnt, 0);
        check_vec("rstmid_busy", busy, 0);
        step(); step();
        wr_idx = 0;
        rst = 1'b0;

        // Enable dropped with two beats buffered: both still delivered.
        enable = 1'b1;
        for (int i = 'h40; i < 'h44; i++) push(8'(i));
        repeat (5) step();
        enable = 1'b0;
        #1;
        check_vec("en_off_no_read", fifo_read, 0);
        m_ready = 1'b1;
        wait_acc(2, 20);
        step(); step();
        check_vec("en_off_count", acc_cnt, 2);
        check_vec("en_off_busy", busy, 0);
        check_vec("en_off_valid", m_valid, 0);
        enable = 1'b1;
        wait_idle(50);
        check_vec("en_on_count", acc_cnt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
